// File: rtl/spi_module_slave_if.sv
// Pin and host-side bundle for spi_module_slave.
// Covers the SPI wires plus the byte-level TX/RX handshake.
`default_nettype none

interface spi_module_slave_if;
  logic       I_spi_sck;
  logic       I_spi_cs;
  logic       I_spi_mosi;
  logic       O_spi_miso;
  logic [7:0] iData;
  logic       I_tx_load;
  logic       O_tx_ready;
  logic [7:0] oData;
  logic       oValid;
  logic       O_underrun;
  logic       O_busy;

  modport slave (
    input  I_spi_sck, I_spi_cs, I_spi_mosi, iData, I_tx_load,
    output O_spi_miso, O_tx_ready, oData, oValid, O_underrun, O_busy
  );

  modport master (
    output I_spi_sck, I_spi_cs, I_spi_mosi, iData, I_tx_load,
    input  O_spi_miso, O_tx_ready, oData, oValid, O_underrun, O_busy
  );
endinterface

`default_nettype wire

// File: rtl/spi_module_slave.sv
// SPI slave, all four CPOL/CPHA modes, oversampled by CLOCK.
// Rev 1.0 - single holding register for TX, underrun signalled with 8'hFF.
`default_nettype none

module spi_module_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic          CLOCK,
  input  wire logic          RESET,
  input  wire logic          CPOL,
  input  wire logic          CPHA,
  spi_module_slave_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   cs_prev_q;

  state_t     state_q,    state_d;
  logic [2:0] cnt_q,      cnt_d;
  logic [7:0] rx_q,       rx_d;
  logic [7:0] tx_q,       tx_d;
  logic       miso_q,     miso_d;
  logic [7:0] hold_q,     hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] odata_q,    odata_d;
  logic       ovalid_q,   ovalid_d;
  logic       under_q,    under_d;
  logic       msb_pend_q, msb_pend_d;

  logic       sck_s;
  logic       cs_s;
  logic       mosi_s;
  logic       cs_rise;
  logic       lead_edge;
  logic       trail_edge;
  logic       sample_edge;
  logic       shift_edge;
  logic       boundary;
  logic [7:0] next_byte;
  logic [7:0] rx_shifted;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign cs_rise     = cs_s & ~cs_prev_q;
  assign lead_edge   = (sck_s != CPOL) && (sck_prev_q == CPOL);
  assign trail_edge  = (sck_s == CPOL) && (sck_prev_q != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  assign next_byte  = hold_vld_q ? hold_q : 8'hFF;
  assign rx_shifted = {rx_q[6:0], mosi_s};

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  bus.I_spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.I_spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.I_spi_mosi};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      miso_q     <= 1'b0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      odata_q    <= 8'h00;
      ovalid_q   <= 1'b0;
      under_q    <= 1'b0;
      msb_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      odata_q    <= odata_d;
      ovalid_q   <= ovalid_d;
      under_q    <= under_d;
      msb_pend_q <= msb_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    odata_d    = odata_q;
    ovalid_d   = 1'b0;
    under_d    = 1'b0;
    msb_pend_d = msb_pend_q;
    boundary   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d     = 1'b0;
        cnt_d      = 3'd0;
        msb_pend_d = 1'b0;
        if (cs_rise) begin
          state_d    = ST_ACTIVE;
          boundary   = 1'b1;
          miso_d     = next_byte[7];
          msb_pend_d = CPHA;
        end
      end
      ST_ACTIVE: begin
        if (!cs_s) begin
          state_d    = ST_IDLE;
          cnt_d      = 3'd0;
          miso_d     = 1'b0;
          msb_pend_d = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_d  = rx_shifted;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              odata_d    = rx_shifted;
              ovalid_d   = 1'b1;
              boundary   = 1'b1;
              msb_pend_d = 1'b1;
            end
          end
          // A freshly loaded byte puts its MSB out without advancing the shifter.
          if (shift_edge) begin
            if (msb_pend_q) begin
              miso_d     = tx_q[7];
              msb_pend_d = 1'b0;
            end else begin
              tx_d   = {tx_q[6:0], 1'b0};
              miso_d = tx_q[6];
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
        cnt_d   = 3'd0;
      end
    endcase

    if (boundary) begin
      tx_d       = next_byte;
      hold_vld_d = 1'b0;
      under_d    = ~hold_vld_q;
    end

    // The holding register is free either when empty or when it drains this cycle.
    if (bus.I_tx_load && (!hold_vld_q || boundary)) begin
      hold_d     = bus.iData;
      hold_vld_d = 1'b1;
    end
  end

  assign bus.O_spi_miso = miso_q;
  assign bus.O_tx_ready = ~hold_vld_q;
  assign bus.oData      = odata_q;
  assign bus.oValid     = ovalid_q;
  assign bus.O_underrun = under_q;
  assign bus.O_busy     = cs_s;

endmodule

`default_nettype wire

// File: doc/spi_module_slave.md
SPI_MODULE_SLAVE -- requirements
Module: spi_module_slave

Interface
REQ-001 The block SHALL have one parameter: SYNC_STAGES, default 2, the number of synchronizer flops on I_spi_sck, I_spi_cs and I_spi_mosi (legal range 2..3).
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- CLOCK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- CPOL  in  1  SCK idle level; static while I_spi_cs is high.
- CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge; static while I_spi_cs is high.
- I_spi_sck  in  1  SPI clock from the master.
- I_spi_cs  in  1  chip select, active-high (high = transfer in progress).
- I_spi_mosi  in  1  master-out serial data.
- O_spi_miso  out  1  slave-out serial data, MSB first.
- iData  in  8  byte to transmit.
- I_tx_load  in  1  write strobe for iData.
- O_tx_ready  out  1  transmit holding register empty.
- oData  out  8  last received byte.
- oValid  out  1  one-cycle pulse, oData updated.
- O_underrun  out  1  one-cycle pulse, byte started with an empty holding register.
- O_busy  out  1  synchronized CS is high.

Function
REQ-003 The block SHALL pass I_spi_sck, I_spi_cs and I_spi_mosi through SYNC_STAGES flops each, and SHALL detect edges by comparing the last synchronized stage with one further registered copy.
REQ-004 The block SHALL define the leading edge as the SCK transition away from CPOL and the trailing edge as the transition back to CPOL; the sample edge is leading if CPHA=0 and trailing if CPHA=1; the shift edge is the other one.
REQ-005 The block SHALL support SCK frequency up to CLOCK/8 with SCK high and low phases of at least 4 CLOCK periods each; faster SCK is out of scope.
REQ-006 The FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on synchronized CS rise; ACTIVE->IDLE on synchronized CS fall; no other transitions.
REQ-007 On IDLE->ACTIVE, the block SHALL clear the 3-bit bit counter, load the TX shift register from the holding register, and drive bit 7 of the loaded byte on O_spi_miso in the same cycle, so that it is valid before the first sample edge when CPHA=0.
REQ-008 In ACTIVE, on each sample edge, the block SHALL shift the synchronized MOSI into the LSB of the RX shift register and increment the bit counter modulo 8.
REQ-009 In ACTIVE, on each shift edge, the block SHALL advance the TX shift register and drive the next bit on O_spi_miso, with these exceptions: with CPHA=1 the first leading edge of a byte drives bit 7 and does not advance; with CPHA=0 the shift edge following the 8th sample drives bit 7 of the next byte.
REQ-010 On the 8th sample edge of a byte (counter 7->0), the block SHALL write the completed byte to oData and pulse oValid high for exactly one cycle, in the cycle after the edge is detected.
REQ-011 At each byte boundary (CS rise, or counter wrap with CS still high), the block SHALL move the holding register into the TX shift register and set O_tx_ready to 1 in the next cycle; back-to-back bytes SHALL need no idle SCK cycles.
REQ-012 If the holding register is empty at a byte boundary, the block SHALL transmit 8'hFF and pulse O_underrun for one cycle.
REQ-013 I_tx_load with O_tx_ready=1 SHALL capture iData and clear O_tx_ready next cycle; I_tx_load with O_tx_ready=0 SHALL be ignored.
REQ-014 If I_tx_load coincides with a byte-boundary transfer, the boundary transfer SHALL use the old holding contents (or 8'hFF if empty), and the new iData SHALL be captured, with O_tx_ready ending 0.
REQ-015 CS fall mid-byte SHALL abort the byte: partial RX data is discarded, no oValid, bit counter cleared; an untransmitted holding byte SHALL be retained.
REQ-016 In IDLE, the block SHALL hold O_spi_miso at 0 and ignore SCK edges.
REQ-017 oData SHALL hold its value until the next oValid.
REQ-018 O_busy SHALL equal the synchronized CS.

Reset
REQ-019 While RESET=0, the block SHALL force: oData=8'h00, oValid=0, O_underrun=0, O_busy=0, O_spi_miso=0, O_tx_ready=1, holding register empty, FSM=IDLE, bit counter=0, all synchronizer flops=0.
REQ-020 Reset assertion mid-byte SHALL abort the transfer without an oValid pulse.
REQ-021 After reset release, the first transfer SHALL start only on a CS rise observed after release.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Mode 0: load 8'hA5; master sends 8'h3C at CLOCK/8 -> MISO carries A5 MSB first, oData=3C, one oValid pulse, O_tx_ready=1.
- Modes 1, 2, 3: the same exchange with 8'h96/8'h69 -> correct bytes in both directions in every mode.
- Burst: two bytes 8'h01 then 8'h80 under one CS, second byte loaded during the first -> two oValid pulses, MISO 01 then 80, no O_underrun.
- Underrun: no load before CS rise -> MISO=FF, O_underrun one pulse, RX still correct.
- Abort: CS drops after 5 bits -> no oValid, oData unchanged; next full transfer is correct.
- Reset: RESET=0 mid-byte -> all outputs at reset values; the transfer after release is correct.
